// File: rtl/rr_mux_arbiter_if.sv
// rr_mux_arbiter_if
// -----------------
// Bundles the producer-side and consumer-side signals of the round-robin
// mux arbiter. N = 2**SEL_WIDTH requesters.
//
// Handshake (valid/ready): the output word in dat_out/sel_out is offered while
// vld_out=1 and is transferred on the rising edge where vld_out && rdy_in.
// While vld_out=1 and rdy_in=0 the offered word and its select are held
// unchanged. Requesters get a one-cycle, one-hot gnt_out pulse in the cycle
// after their word was captured, and must drop or advance that word then.
//
// Signals:
//   req_in  [N]            per-requester pending flag         (producer -> arb)
//   dat_in  [N*DAT_WIDTH]  requester words, slice i = word i  (producer -> arb)
//   gnt_out [N]            one-hot one-cycle grant            (arb -> producer)
//   sel_out [SEL_WIDTH]    index of the most recent winner    (arb -> consumer)
//   vld_out                dat_out holds a valid word         (arb -> consumer)
//   rdy_in                 consumer accepts dat_out           (consumer -> arb)
//   dat_out [DAT_WIDTH]    registered selected word           (arb -> consumer)
//
// Modports: slave = the arbiter, master = the environment around it.
interface rr_mux_arbiter_if #(
  parameter int DAT_WIDTH = 8,
  parameter int SEL_WIDTH = 4
);
  localparam int N = 1 << SEL_WIDTH;

  logic [N-1:0]           req_in;
  logic [N*DAT_WIDTH-1:0] dat_in;
  logic [N-1:0]           gnt_out;
  logic [SEL_WIDTH-1:0]   sel_out;
  logic                   vld_out;
  logic                   rdy_in;
  logic [DAT_WIDTH-1:0]   dat_out;

  modport slave (
    input  req_in, dat_in, rdy_in,
    output gnt_out, sel_out, vld_out, dat_out
  );

  modport master (
    output req_in, dat_in, rdy_in,
    input  gnt_out, sel_out, vld_out, dat_out
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter
// --------------
// Round-robin arbiter and sequencer for a shared N:1 data mux
// (N = 2**SEL_WIDTH). Picks one pending requester fairly, captures its word
// into a registered output and offers it on a valid/ready port.
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst        asynchronous active-high reset
//   bus        rr_mux_arbiter_if.slave (req/dat in, gnt/sel/vld/dat out, rdy in)
//   state_dbg  current FSM state (0 = IDLE, 1 = HOLD)
//
// Optional feature, macro RR_ARB_PRIO0_EN:
//   defined   - requester 0 is strict high priority whenever it is not masked;
//               a requester-0 win leaves the round-robin pointer untouched.
//   undefined - pure round-robin over all N requesters.
module rr_mux_arbiter #(
  parameter int DAT_WIDTH = 8,
  parameter int SEL_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  rr_mux_arbiter_if.slave     bus,
  output logic                state_dbg
);
  localparam int N = 1 << SEL_WIDTH;

  localparam logic [0:0] ST_IDLE = 1'b0; // output register empty
  localparam logic [0:0] ST_HOLD = 1'b1; // output register full, awaiting rdy_in

  logic [0:0]           state_q, state_d;
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [DAT_WIDTH-1:0] dat_q, dat_d;
  logic                 vld_q, vld_d;
  logic [N-1:0]         gnt_q, gnt_d;

  logic [N-1:0]         elig;
  logic                 win_found;
  logic [SEL_WIDTH-1:0] win_idx;
  logic [SEL_WIDTH-1:0] scan_idx;
  logic [DAT_WIDTH-1:0] win_dat;
  logic                 free;

  // Arbitration. The previous winner still shows req_in high during its
  // gnt_out cycle, so it is masked out to avoid granting the same word twice.
  always_comb begin
    elig      = bus.req_in & ~gnt_q;
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
`ifdef RR_ARB_PRIO0_EN
    if (elig[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
    end
`endif
    // Scan ptr+1, ptr+2, ... ; the SEL_WIDTH-bit sum wraps modulo N, and
    // k = N lands on ptr itself as the last candidate.
    for (int k = 1; k <= N; k++) begin
      scan_idx = ptr_q + SEL_WIDTH'(k);
      if (!win_found && elig[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Data mux for the winning slice.
  always_comb begin
    win_dat = '0;
    for (int i = 0; i < N; i++) begin
      if (win_idx == SEL_WIDTH'(i)) begin
        win_dat = bus.dat_in[i*DAT_WIDTH +: DAT_WIDTH];
      end
    end
  end

  // The arbiter may load a new word when the output register is empty, or
  // when the held word is being accepted on this same edge.
  assign free = (state_q == ST_IDLE) || bus.rdy_in;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    vld_d   = vld_q;
    gnt_d   = '0;
    if (free) begin
      if (win_found) begin
        dat_d          = win_dat;
        sel_d          = win_idx;
        vld_d          = 1'b1;
        gnt_d[win_idx] = 1'b1;
        state_d        = ST_HOLD;
`ifdef RR_ARB_PRIO0_EN
        if (win_idx != '0) begin
          ptr_d = win_idx;
        end
`else
        ptr_d = win_idx;
`endif
      end else begin
        vld_d   = 1'b0;
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= SEL_WIDTH'(N - 1); // requester 0 gets first priority
      sel_q   <= '0;
      dat_q   <= '0;
      vld_q   <= 1'b0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      vld_q   <= vld_d;
      gnt_q   <= gnt_d;
    end
  end

  assign bus.gnt_out = gnt_q;
  assign bus.sel_out = sel_q;
  assign bus.vld_out = vld_q;
  assign bus.dat_out = dat_q;
  assign state_dbg   = state_q;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter
// -----------------
// Self-checking bench for rr_mux_arbiter with N = 4 requesters. A behavioural
// model (integer pointer, index of last grant, held word) predicts every
// output after every edge; an expected queue tracks words handed downstream.
module tb_rr_mux_arbiter;
  localparam int DW = 8;
  localparam int SW = 2;
  localparam int N  = 1 << SW;
`ifdef RR_ARB_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  logic clk;
  logic rst;
  logic state_dbg;

  rr_mux_arbiter_if #(.DAT_WIDTH(DW), .SEL_WIDTH(SW)) bus ();

  rr_mux_arbiter #(.DAT_WIDTH(DW), .SEL_WIDTH(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] words [N];   // word offered by each requester
  logic [DW-1:0] exp_q [$];   // words expected to be accepted downstream

  int            m_ptr;       // last round-robin winner
  int            m_gnt;       // requester granted by the last edge, -1 none
  int            m_sel;
  logic [DW-1:0] m_dat;
  bit            m_vld;

  task automatic model_reset();
    m_ptr = N - 1;
    m_gnt = -1;
    m_sel = 0;
    m_dat = '0;
    m_vld = 1'b0;
    exp_q.delete();
  endtask

  function automatic int pick(input logic [N-1:0] req);
    if (PRIO0 && req[0] && m_gnt != 0) return 0;
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (req[i] && i != m_gnt) return i;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [N-1:0] req, input bit rdy);
    int w;
    if (!m_vld || rdy) begin
      w = pick(req);
      if (w >= 0) begin
        m_dat = words[w];
        m_sel = w;
        m_vld = 1'b1;
        m_gnt = w;
        if (!(PRIO0 && w == 0)) m_ptr = w;
        exp_q.push_back(words[w]);
      end else begin
        m_vld = 1'b0;
        m_gnt = -1;
      end
    end else begin
      m_gnt = -1;
    end
  endtask

  task automatic compare_all(input string pfx);
    logic [N-1:0] g;
    g = '0;
    if (m_gnt >= 0) g[m_gnt] = 1'b1;
    check({pfx, "_gnt"},   32'(bus.gnt_out), 32'(g));
    check({pfx, "_vld"},   32'(bus.vld_out), 32'(m_vld));
    check({pfx, "_sel"},   32'(bus.sel_out), 32'(m_sel));
    check({pfx, "_dat"},   32'(bus.dat_out), 32'(m_dat));
    check({pfx, "_state"}, 32'(state_dbg),   32'(m_vld));
  endtask

  // ---------------- driver ----------------
  // One clock: drive inputs at the falling edge, predict, check after the rise.
  task automatic cycle(input logic [N-1:0] req, input bit rdy, input string pfx);
    logic [N*DW-1:0] packed_w;
    @(negedge clk);
    for (int i = 0; i < N; i++) packed_w[i*DW +: DW] = words[i];
    bus.req_in = req;
    bus.rdy_in = rdy;
    bus.dat_in = packed_w;
    // A word offered now and accepted at the coming edge must be the oldest expected.
    if (bus.vld_out && rdy) begin
      check("acc_avail", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("acc_word", 32'(bus.dat_out), 32'(exp_q.pop_front()));
    end
    model_step(req, rdy);
    @(posedge clk);
    #1;
    compare_all(pfx);
  endtask

  // ---------------- stimulus ----------------
  logic [N-1:0] rot_gnt [5];
  logic [DW-1:0] rot_dat [5];
  logic [N-1:0] prev_g;
  int last_masked;

  initial begin
    rst        = 1'b1;
    bus.req_in = '0;
    bus.rdy_in = 1'b0;
    bus.dat_in = '0;
    for (int i = 0; i < N; i++) words[i] = '0;
    model_reset();

    // Reset state
    @(posedge clk); #1;
    compare_all("rst");
    rst = 1'b0;

    // Reset in the middle of HOLD, with the grant pulse still high
    words[2] = 8'h33;
    cycle(4'b0100, 1'b1, "pre");
    check("pre_gnt2", 32'(bus.gnt_out), 32'h4);
    #2 rst = 1'b1;
    #1;
    check("arst_vld", 32'(bus.vld_out), 32'd0);
    check("arst_gnt", 32'(bus.gnt_out), 32'd0);
    check("arst_dat", 32'(bus.dat_out), 32'd0);
    model_reset();
    @(posedge clk); #1;
    compare_all("arst");
    rst = 1'b0;

    // All-request rotation straight after reset
    for (int i = 0; i < N; i++) words[i] = 8'hA0 + DW'(i);
    if (PRIO0) begin
      rot_gnt = '{4'b0001, 4'b0010, 4'b0001, 4'b0100, 4'b0001};
      rot_dat = '{8'hA0, 8'hA1, 8'hA0, 8'hA2, 8'hA0};
    end else begin
      rot_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      rot_dat = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
    end
    for (int i = 0; i < 5; i++) begin
      cycle(4'b1111, 1'b1, "rot");
      check("rot_seq_gnt", 32'(bus.gnt_out), 32'(rot_gnt[i]));
      check("rot_seq_dat", 32'(bus.dat_out), 32'(rot_dat[i]));
    end

    // Backpressure: hold requester 2's word while req_in wanders
    cycle(4'b0000, 1'b1, "bp_idle");
    words[2] = 8'h5C;
    cycle(4'b0100, 1'b1, "bp_grant");
    for (int i = 0; i < 5; i++) begin
      words[2] = DW'($urandom_range(0, 255));
      cycle(N'($urandom_range(0, N*N - 1)), 1'b0, "bp_stall");
      check("bp_dat", 32'(bus.dat_out), 32'h5C);
      check("bp_sel", 32'(bus.sel_out), 32'd2);
      check("bp_vld", 32'(bus.vld_out), 32'd1);
      check("bp_gnt", 32'(bus.gnt_out), 32'd0);
    end
    cycle(4'b1011, 1'b1, "bp_release");
    check("bp_b2b_vld", 32'(bus.vld_out), 32'd1);
    check("bp_b2b_gnt", 32'(bus.gnt_out != '0), 32'd1);

    // Wrap-around: make requester 3 the last winner, then 1001 -> 0, then 3
    cycle(4'b0000, 1'b1, "wr_idle");
    cycle(4'b1000, 1'b1, "wr_set");
    cycle(4'b0000, 1'b1, "wr_idle2");
    cycle(4'b1001, 1'b1, "wr_a");
    check("wrap_to_0", 32'(bus.gnt_out), 32'h1);
    cycle(4'b1001, 1'b1, "wr_b");
    check("wrap_to_3", 32'(bus.gnt_out), 32'h8);

    // Idle gap: single one-cycle request
    cycle(4'b0000, 1'b1, "gap0");
    cycle(4'b0010, 1'b1, "gap1");
    check("gap_gnt", 32'(bus.gnt_out), 32'h2);
    check("gap_vld1", 32'(bus.vld_out), 32'd1);
    cycle(4'b0000, 1'b1, "gap2");
    check("gap_vld0", 32'(bus.vld_out), 32'd0);
    check("gap_state", 32'(state_dbg), 32'd0);

`ifdef RR_ARB_PRIO0_EN
    // Requester 0 wins whenever unmasked; 1 and 2 share the masked cycles
    last_masked = -1;
    prev_g = '0;
    for (int i = 0; i < 12; i++) begin
      cycle(4'b0111, 1'b1, "prio");
      if (prev_g == 4'b0001) begin
        check("prio_other", 32'(bus.gnt_out == 4'b0010 || bus.gnt_out == 4'b0100), 32'd1);
        if (last_masked >= 0) check("prio_alt", 32'(bus.gnt_out), 32'(last_masked == 1 ? 4'b0100 : 4'b0010));
        last_masked = (bus.gnt_out == 4'b0010) ? 1 : 2;
      end else begin
        check("prio_zero", 32'(bus.gnt_out), 32'h1);
      end
      prev_g = bus.gnt_out;
    end
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      for (int j = 0; j < N; j++) words[j] = DW'($urandom_range(0, 255));
      cycle(N'($urandom_range(0, N*N - 1)), ($urandom_range(0, 3) != 0), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
